// File: rtl/ascon_block_sequencer_pkg.sv
// Shared definitions for the Ascon-AEAD128 block sequencer: state encoding,
// block-class modes and the rate-block padding/masking helpers.
package ascon_block_sequencer_pkg;

    localparam logic         AD_MODE        = 1'b1;
    localparam logic         AE_MODE        = 1'b0;
    localparam logic [7:0]   PAD_BYTE       = 8'h01;
    localparam logic [4:0]   FULL_BYTES     = 5'd16;
    localparam logic [127:0] PAD_ONLY_BLOCK = 128'h1;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_INIT     = 3'd1,
        SEQ_AD       = 3'd2,
        SEQ_AD_PAD   = 3'd3,
        SEQ_MSG      = 3'd4,
        SEQ_MSG_PAD  = 3'd5,
        SEQ_CT_WAIT  = 3'd6,
        SEQ_TAG_WAIT = 3'd7
    } ascon_seq_state;

    // What the core's next ciphertext pulse belongs to.
    typedef struct packed {
        logic [4:0] bytes;
        logic       last;
        logic       discard;
    } ct_side_t;

    // Keep bytes below 'bytes', place PAD_BYTE at index 'bytes', zero the rest.
    function automatic logic [127:0] pad_block(input logic [127:0] data, input logic [4:0] bytes);
        logic [127:0] blk;
        blk = 128'h0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < bytes) begin
                blk[8*i +: 8] = data[8*i +: 8];
            end else if (5'(i) == bytes) begin
                blk[8*i +: 8] = PAD_BYTE;
            end else begin
                blk[8*i +: 8] = 8'h00;
            end
        end
        return blk;
    endfunction

    // Keep bytes below 'bytes' and force every byte above to zero.
    function automatic logic [127:0] mask_block(input logic [127:0] data, input logic [4:0] bytes);
        logic [127:0] blk;
        blk = 128'h0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < bytes) begin
                blk[8*i +: 8] = data[8*i +: 8];
            end else begin
                blk[8*i +: 8] = 8'h00;
            end
        end
        return blk;
    endfunction

endpackage

// File: rtl/ascon_block_sequencer_ct_buffer.sv
// One-entry ciphertext output register with its side register ({bytes, last,
// discard}) and the ct_pending flag that throttles new message blocks.
module ascon_ct_buffer
    import ascon_block_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [4:0]   push_bytes_i,
    input  logic         push_last_i,
    input  logic         push_discard_i,
    input  logic [127:0] ct_data_i,
    input  logic         ct_valid_i,
    output logic         ct_pending_o,
    output logic [127:0] m_ct_data_o,
    output logic [4:0]   m_ct_bytes_o,
    output logic         m_ct_last_o,
    output logic         m_ct_valid_o,
    input  logic         m_ct_ready_i
);

    ct_side_t     side_q, side_d;
    logic         pending_q, pending_d;
    logic [127:0] data_q, data_d;
    logic [4:0]   bytes_q, bytes_d;
    logic         last_q, last_d;
    logic         valid_q, valid_d;

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_q    <= '{bytes: 5'd0, last: 1'b0, discard: 1'b0};
            pending_q <= 1'b0;
            data_q    <= 128'h0;
            bytes_q   <= 5'd0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            side_q    <= side_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            bytes_q   <= bytes_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    // Push, ciphertext load and sink handshake are mutually exclusive because
    // a push is only issued while nothing is pending.
    always_comb begin
        side_d    = side_q;
        pending_d = pending_q;
        data_d    = data_q;
        bytes_d   = bytes_q;
        last_d    = last_q;
        valid_d   = valid_q;
        if (push_i) begin
            side_d    = '{bytes: push_bytes_i, last: push_last_i, discard: push_discard_i};
            pending_d = 1'b1;
        end else if (ct_valid_i && pending_q && !valid_q) begin
            if (side_q.discard) begin
                pending_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                data_d  = mask_block(ct_data_i, side_q.bytes);
                bytes_d = side_q.bytes;
                last_d  = side_q.last;
            end
        end else if (valid_q && m_ct_ready_i) begin
            valid_d   = 1'b0;
            pending_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign ct_pending_o = pending_q;
    assign m_ct_data_o  = data_q;
    assign m_ct_bytes_o = bytes_q;
    assign m_ct_last_o  = last_q;
    assign m_ct_valid_o = valid_q;

endmodule

// File: rtl/ascon_block_sequencer.sv
// Stream front-end for the Ascon-AEAD128 core: pads AD/message beats into
// rate blocks, inserts the extra pad blocks, trims ciphertext, captures the tag.
module ascon_block_sequencer
    import ascon_block_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         ad_empty_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] s_ad_data_i,
    input  logic [4:0]   s_ad_bytes_i,
    input  logic         s_ad_last_i,
    input  logic         s_ad_valid_i,
    output logic         s_ad_ready_o,
    input  logic [127:0] s_msg_data_i,
    input  logic [4:0]   s_msg_bytes_i,
    input  logic         s_msg_last_i,
    input  logic         s_msg_valid_i,
    output logic         s_msg_ready_o,
    output logic         core_start_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_nonce_o,
    output logic [127:0] core_blk_data_o,
    output logic         core_blk_ad_o,
    output logic         core_blk_last_o,
    output logic         core_blk_valid_o,
    input  logic         core_blk_ready_i,
    input  logic [127:0] core_ct_data_i,
    input  logic         core_ct_valid_i,
    input  logic [127:0] core_tag_i,
    input  logic         core_tag_valid_i,
    output logic [127:0] m_ct_data_o,
    output logic [4:0]   m_ct_bytes_o,
    output logic         m_ct_last_o,
    output logic         m_ct_valid_o,
    input  logic         m_ct_ready_i,
    output logic [127:0] tag_o,
    output logic         busy_o,
    output logic         done_o
);

    ascon_seq_state state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic           ad_empty_q, ad_empty_d;
    logic           core_start_q, core_start_d;
    logic           done_q, done_d;
    logic [127:0]   tag_q, tag_d;

    logic           ct_pending_s;
    logic           blk_hs_s;
    logic           push_s;
    logic [4:0]     push_bytes_s;
    logic           push_last_s;
    logic           push_discard_s;
    logic           ad_full_s;
    logic           msg_full_s;

    assign ad_full_s  = (s_ad_bytes_i == FULL_BYTES);
    assign msg_full_s = (s_msg_bytes_i == FULL_BYTES);
    assign blk_hs_s   = core_blk_valid_o && core_blk_ready_i;

    // State and sampled-context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            key_q        <= 128'h0;
            nonce_q      <= 128'h0;
            ad_empty_q   <= 1'b0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            tag_q        <= 128'h0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            ad_empty_q   <= ad_empty_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            tag_q        <= tag_d;
        end
    end

    // Next-state and context update.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        ad_empty_d   = ad_empty_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;
        tag_d        = tag_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    key_d        = key_i;
                    nonce_d      = nonce_i;
                    ad_empty_d   = ad_empty_i;
                    core_start_d = 1'b1;
                    state_d      = SEQ_INIT;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_INIT: begin
                state_d = ad_empty_q ? SEQ_MSG : SEQ_AD;
            end
            SEQ_AD: begin
                if (blk_hs_s && s_ad_last_i) begin
                    state_d = ad_full_s ? SEQ_AD_PAD : SEQ_MSG;
                end else begin
                    state_d = SEQ_AD;
                end
            end
            SEQ_AD_PAD: begin
                state_d = blk_hs_s ? SEQ_MSG : SEQ_AD_PAD;
            end
            SEQ_MSG: begin
                if (blk_hs_s && s_msg_last_i) begin
                    state_d = msg_full_s ? SEQ_MSG_PAD : SEQ_CT_WAIT;
                end else begin
                    state_d = SEQ_MSG;
                end
            end
            SEQ_MSG_PAD: begin
                state_d = blk_hs_s ? SEQ_TAG_WAIT : SEQ_MSG_PAD;
            end
            SEQ_CT_WAIT: begin
                state_d = ct_pending_s ? SEQ_CT_WAIT : SEQ_TAG_WAIT;
            end
            SEQ_TAG_WAIT: begin
                if (core_tag_valid_i) begin
                    tag_d   = core_tag_i;
                    done_d  = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_TAG_WAIT;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Stream-to-core pass-through with the pad mux; a full last beat keeps
    // core_blk_last low because a separate pad block follows it.
    always_comb begin
        s_ad_ready_o     = 1'b0;
        s_msg_ready_o    = 1'b0;
        core_blk_valid_o = 1'b0;
        core_blk_data_o  = 128'h0;
        core_blk_ad_o    = AE_MODE;
        core_blk_last_o  = 1'b0;
        push_s           = 1'b0;
        push_bytes_s     = 5'd0;
        push_last_s      = 1'b0;
        push_discard_s   = 1'b0;
        case (state_q)
            SEQ_AD: begin
                s_ad_ready_o     = core_blk_ready_i;
                core_blk_valid_o = s_ad_valid_i;
                core_blk_data_o  = pad_block(s_ad_data_i, s_ad_bytes_i);
                core_blk_ad_o    = AD_MODE;
                core_blk_last_o  = s_ad_last_i && !ad_full_s;
            end
            SEQ_AD_PAD: begin
                core_blk_valid_o = 1'b1;
                core_blk_data_o  = PAD_ONLY_BLOCK;
                core_blk_ad_o    = AD_MODE;
                core_blk_last_o  = 1'b1;
            end
            SEQ_MSG: begin
                s_msg_ready_o    = core_blk_ready_i && !ct_pending_s;
                core_blk_valid_o = s_msg_valid_i && !ct_pending_s;
                core_blk_data_o  = pad_block(s_msg_data_i, s_msg_bytes_i);
                core_blk_ad_o    = AE_MODE;
                core_blk_last_o  = s_msg_last_i && !msg_full_s;
                push_s           = s_msg_valid_i && core_blk_ready_i && !ct_pending_s;
                push_bytes_s     = s_msg_bytes_i;
                push_last_s      = s_msg_last_i && !msg_full_s;
            end
            SEQ_MSG_PAD: begin
                core_blk_valid_o = !ct_pending_s;
                core_blk_data_o  = PAD_ONLY_BLOCK;
                core_blk_ad_o    = AE_MODE;
                core_blk_last_o  = 1'b1;
                push_s           = core_blk_ready_i && !ct_pending_s;
                push_last_s      = 1'b1;
                push_discard_s   = 1'b1;
            end
            default: begin
                core_blk_valid_o = 1'b0;
            end
        endcase
    end

    ascon_ct_buffer u_ct_buffer (
        .clk            (clk),
        .rst            (rst),
        .push_i         (push_s),
        .push_bytes_i   (push_bytes_s),
        .push_last_i    (push_last_s),
        .push_discard_i (push_discard_s),
        .ct_data_i      (core_ct_data_i),
        .ct_valid_i     (core_ct_valid_i),
        .ct_pending_o   (ct_pending_s),
        .m_ct_data_o    (m_ct_data_o),
        .m_ct_bytes_o   (m_ct_bytes_o),
        .m_ct_last_o    (m_ct_last_o),
        .m_ct_valid_o   (m_ct_valid_o),
        .m_ct_ready_i   (m_ct_ready_i)
    );

    assign core_start_o = core_start_q;
    assign core_key_o   = key_q;
    assign core_nonce_o = nonce_q;
    assign tag_o        = tag_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed bench for ascon_block_sequencer: a small behavioural core answers
// each message block with block ^ KS and pulses the tag after the final block.
module tb_ascon_block_sequencer;

    localparam logic [127:0] KS = {16{8'h5A}};

    logic         clk, rst;
    logic         start_i, ad_empty_i;
    logic [127:0] key_i, nonce_i;
    logic [127:0] s_ad_data_i;
    logic [4:0]   s_ad_bytes_i;
    logic         s_ad_last_i, s_ad_valid_i, s_ad_ready_o;
    logic [127:0] s_msg_data_i;
    logic [4:0]   s_msg_bytes_i;
    logic         s_msg_last_i, s_msg_valid_i, s_msg_ready_o;
    logic         core_start_o;
    logic [127:0] core_key_o, core_nonce_o, core_blk_data_o;
    logic         core_blk_ad_o, core_blk_last_o, core_blk_valid_o, core_blk_ready_i;
    logic [127:0] core_ct_data_i, core_tag_i;
    logic         core_ct_valid_i, core_tag_valid_i;
    logic [127:0] m_ct_data_o;
    logic [4:0]   m_ct_bytes_o;
    logic         m_ct_last_o, m_ct_valid_o, m_ct_ready_i;
    logic [127:0] tag_o;
    logic         busy_o, done_o;

    ascon_block_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .ad_empty_i(ad_empty_i),
        .key_i(key_i), .nonce_i(nonce_i),
        .s_ad_data_i(s_ad_data_i), .s_ad_bytes_i(s_ad_bytes_i), .s_ad_last_i(s_ad_last_i),
        .s_ad_valid_i(s_ad_valid_i), .s_ad_ready_o(s_ad_ready_o),
        .s_msg_data_i(s_msg_data_i), .s_msg_bytes_i(s_msg_bytes_i), .s_msg_last_i(s_msg_last_i),
        .s_msg_valid_i(s_msg_valid_i), .s_msg_ready_o(s_msg_ready_o),
        .core_start_o(core_start_o), .core_key_o(core_key_o), .core_nonce_o(core_nonce_o),
        .core_blk_data_o(core_blk_data_o), .core_blk_ad_o(core_blk_ad_o),
        .core_blk_last_o(core_blk_last_o), .core_blk_valid_o(core_blk_valid_o),
        .core_blk_ready_i(core_blk_ready_i),
        .core_ct_data_i(core_ct_data_i), .core_ct_valid_i(core_ct_valid_i),
        .core_tag_i(core_tag_i), .core_tag_valid_i(core_tag_valid_i),
        .m_ct_data_o(m_ct_data_o), .m_ct_bytes_o(m_ct_bytes_o), .m_ct_last_o(m_ct_last_o),
        .m_ct_valid_o(m_ct_valid_o), .m_ct_ready_i(m_ct_ready_i),
        .tag_o(tag_o), .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct packed { logic [127:0] data; logic ad; logic last; } blk_t;
    typedef struct packed { logic [127:0] data; logic [4:0] bytes; logic last; } ct_t;
    typedef struct {
        logic [127:0] data;
        logic [4:0]   bytes;
        logic [127:0] exp_blk;
        logic [127:0] exp_ct;
        logic         exp_ct_last;
        int           nblk;
    } vec_t;

    blk_t         blk_q[$];
    ct_t          ct_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cs_cnt = 0;
    int           done_cnt = 0;
    int           tag_delay = 8;
    logic [127:0] cs_key, cs_nonce;
    vec_t         vecs[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural core: ct one cycle after each message block, tag after the final one.
    initial begin : core_model
        logic hs;
        blk_t b;
        int   tag_cnt;
        tag_cnt = 0;
        core_ct_valid_i = 1'b0;
        core_ct_data_i = 128'h0;
        core_tag_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            hs = core_blk_valid_o && core_blk_ready_i && !rst;
            b = '{data: core_blk_data_o, ad: core_blk_ad_o, last: core_blk_last_o};
            if (hs) blk_q.push_back(b);
            @(posedge clk);
            #1;
            core_ct_valid_i = 1'b0;
            core_tag_valid_i = 1'b0;
            if (rst) begin
                tag_cnt = 0;
            end else begin
                if (tag_cnt > 0) begin
                    tag_cnt--;
                    if (tag_cnt == 0) core_tag_valid_i = 1'b1;
                end
                if (hs && !b.ad) begin
                    core_ct_valid_i = 1'b1;
                    core_ct_data_i = b.data ^ KS;
                    if (b.last) tag_cnt = tag_delay;
                end
            end
        end
    end

    // Observers for core_start, ciphertext beats, done latency and ct overlap.
    initial begin : monitors
        logic tag_prev;
        tag_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start_o) begin
                cs_cnt++;
                cs_key = core_key_o;
                cs_nonce = core_nonce_o;
            end
            if (m_ct_valid_o && m_ct_ready_i)
                ct_q.push_back('{data: m_ct_data_o, bytes: m_ct_bytes_o, last: m_ct_last_o});
            if (done_o) done_cnt++;
            if (core_ct_valid_i && m_ct_valid_o) begin
                errors++;
                $display("FAIL ct_overlap: core ct arrived while output register full");
            end
            if (tag_prev) check_int("done_after_tag", int'(done_o), 1);
            tag_prev = core_tag_valid_i && !rst;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic empty);
        start_i = 1'b1;
        ad_empty_i = empty;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_ad_accept();
        int n = 0;
        @(negedge clk);
        while (!s_ad_ready_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check_int("ad_accept_timeout", n, 0);
        @(posedge clk);
        #1;
        s_ad_valid_i = 1'b0;
    endtask

    task automatic wait_msg_accept();
        int n = 0;
        @(negedge clk);
        while (!s_msg_ready_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check_int("msg_accept_timeout", n, 0);
        @(posedge clk);
        #1;
        s_msg_valid_i = 1'b0;
    endtask

    task automatic send_ad(input logic [127:0] d, input logic [4:0] b, input logic l);
        s_ad_data_i = d; s_ad_bytes_i = b; s_ad_last_i = l; s_ad_valid_i = 1'b1;
        wait_ad_accept();
    endtask

    task automatic send_msg(input logic [127:0] d, input logic [4:0] b, input logic l);
        s_msg_data_i = d; s_msg_bytes_i = b; s_msg_last_i = l; s_msg_valid_i = 1'b1;
        wait_msg_accept();
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin @(negedge clk); n++; end
        check_int("done_seen", done_cnt - d0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tagname);
        check_int({tagname, "_busy"}, int'(busy_o), 0);
        check_int({tagname, "_s_ad_ready"}, int'(s_ad_ready_o), 0);
        check_int({tagname, "_s_msg_ready"}, int'(s_msg_ready_o), 0);
        check_int({tagname, "_core_start"}, int'(core_start_o), 0);
        check_int({tagname, "_blk_valid"}, int'(core_blk_valid_o), 0);
        check_int({tagname, "_m_ct_valid"}, int'(m_ct_valid_o), 0);
        check_int({tagname, "_done"}, int'(done_o), 0);
        check_vec({tagname, "_tag"}, tag_o, 128'h0);
        check_vec({tagname, "_core_key"}, core_key_o, 128'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cs0, d0;
        logic [127:0] tv;
        blk_q.delete();
        ct_q.delete();
        cs0 = cs_cnt;
        d0 = done_cnt;
        tv = {4{32'(32'hC0DE_0000 + idx)}};
        core_tag_i = tv;
        key_i = {4{32'(32'h1111_0000 + idx)}};
        nonce_i = {4{32'(32'h2222_0000 + idx)}};
        pulse_start(1'b1);
        send_msg(v.data, v.bytes, 1'b1);
        wait_done(d0);
        check_int($sformatf("v%0d_core_start", idx), cs_cnt - cs0, 1);
        check_vec($sformatf("v%0d_core_key", idx), cs_key, key_i);
        check_vec($sformatf("v%0d_core_nonce", idx), cs_nonce, nonce_i);
        check_int($sformatf("v%0d_blk_count", idx), blk_q.size(), v.nblk);
        if (blk_q.size() >= 1) begin
            check_vec($sformatf("v%0d_blk0_data", idx), blk_q[0].data, v.exp_blk);
            check_int($sformatf("v%0d_blk0_ad", idx), int'(blk_q[0].ad), 0);
            check_int($sformatf("v%0d_blk0_last", idx), int'(blk_q[0].last), int'(v.nblk == 1));
        end
        if (blk_q.size() >= 2) begin
            check_vec($sformatf("v%0d_blk1_data", idx), blk_q[1].data, 128'h1);
            check_int($sformatf("v%0d_blk1_last", idx), int'(blk_q[1].last), 1);
        end
        check_int($sformatf("v%0d_ct_count", idx), ct_q.size(), 1);
        if (ct_q.size() >= 1) begin
            check_vec($sformatf("v%0d_ct_data", idx), ct_q[0].data, v.exp_ct);
            check_int($sformatf("v%0d_ct_bytes", idx), int'(ct_q[0].bytes), int'(v.bytes));
            check_int($sformatf("v%0d_ct_last", idx), int'(ct_q[0].last), int'(v.exp_ct_last));
        end
        check_vec($sformatf("v%0d_tag", idx), tag_o, tv);
        check_int($sformatf("v%0d_busy_after", idx), int'(busy_o), 0);
    endtask

    initial begin : main
        int cs0, d0, viol;
        vecs[0] = '{data: {16{8'hFF}}, bytes: 5'd5,
                    exp_blk: 128'h0000_0000_0000_0000_0000_01FF_FFFF_FFFF,
                    exp_ct: 128'h0000_0000_0000_0000_0000_00A5_A5A5_A5A5, exp_ct_last: 1'b1, nblk: 1};
        vecs[1] = '{data: {16{8'hFF}}, bytes: 5'd0, exp_blk: 128'h1,
                    exp_ct: 128'h0, exp_ct_last: 1'b1, nblk: 1};
        vecs[2] = '{data: 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, bytes: 5'd15,
                    exp_blk: 128'h0111_2233_4455_6677_8899_AABB_CCDD_EEFF,
                    exp_ct: 128'h004B_7869_1E0F_3C2D_D2C3_F0E1_9687_B4A5, exp_ct_last: 1'b1, nblk: 1};
        vecs[3] = '{data: 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BE3C, bytes: 5'd1,
                    exp_blk: 128'h0000_0000_0000_0000_0000_0000_0000_013C,
                    exp_ct: 128'h0000_0000_0000_0000_0000_0000_0000_0066, exp_ct_last: 1'b1, nblk: 1};
        vecs[4] = '{data: 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, bytes: 5'd16,
                    exp_blk: 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                    exp_ct: 128'h5554_5756_5150_5352_5D5C_5F5E_5958_5B5A, exp_ct_last: 1'b0, nblk: 2};

        rst = 1'b1;
        start_i = 1'b0; ad_empty_i = 1'b0; key_i = 128'h0; nonce_i = 128'h0;
        s_ad_data_i = 128'h0; s_ad_bytes_i = 5'd0; s_ad_last_i = 1'b0; s_ad_valid_i = 1'b0;
        s_msg_data_i = 128'h0; s_msg_bytes_i = 5'd0; s_msg_last_i = 1'b0; s_msg_valid_i = 1'b0;
        core_blk_ready_i = 1'b1; core_tag_i = 128'h0; m_ct_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // AD beat of exactly 16 bytes with last: data block, then AD pad block.
        blk_q.delete(); ct_q.delete();
        cs0 = cs_cnt; d0 = done_cnt;
        core_tag_i = 128'hA11C_E000_0000_0000_0000_0000_0000_0001;
        pulse_start(1'b0);
        pulse_start(1'b1);
        send_ad(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 5'd16, 1'b1);
        send_msg(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFAA_BBCC, 5'd3, 1'b1);
        wait_done(d0);
        check_int("ad16_core_start", cs_cnt - cs0, 1);
        check_int("ad16_blk_count", blk_q.size(), 3);
        if (blk_q.size() == 3) begin
            check_vec("ad16_blk0", {blk_q[0].data, 6'd0, blk_q[0].ad, blk_q[0].last} >> 8,
                      {128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 8'h02} >> 8);
            check_int("ad16_blk0_ad_last", int'({blk_q[0].ad, blk_q[0].last}), 2);
            check_vec("ad16_blk1_data", blk_q[1].data, 128'h1);
            check_int("ad16_blk1_ad_last", int'({blk_q[1].ad, blk_q[1].last}), 3);
            check_vec("ad16_blk2_data", blk_q[2].data, 128'h0000_0000_0000_0000_0000_0000_01AA_BBCC);
            check_int("ad16_blk2_ad_last", int'({blk_q[2].ad, blk_q[2].last}), 1);
        end
        check_int("ad16_ct_count", ct_q.size(), 1);
        if (ct_q.size() == 1) check_vec("ad16_ct_data", ct_q[0].data, 128'hF0E196);
        check_vec("ad16_tag", tag_o, 128'hA11C_E000_0000_0000_0000_0000_0000_0001);

        // Sink backpressure: second beat must stall until the ciphertext drains.
        blk_q.delete(); ct_q.delete();
        d0 = done_cnt;
        core_tag_i = 128'hBEEF;
        m_ct_ready_i = 1'b0;
        pulse_start(1'b1);
        send_msg({16{8'h11}}, 5'd16, 1'b0);
        s_msg_data_i = {16{8'h22}}; s_msg_bytes_i = 5'd16; s_msg_last_i = 1'b0; s_msg_valid_i = 1'b1;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_msg_ready_o || core_blk_valid_o) viol++;
        end
        check_int("bp_stall_violations", viol, 0);
        check_int("bp_ct_held", int'(m_ct_valid_o), 1);
        check_int("bp_blocks_during_stall", blk_q.size(), 1);
        @(posedge clk);
        #1;
        m_ct_ready_i = 1'b1;
        wait_msg_accept();
        send_msg({16{8'h33}}, 5'd2, 1'b1);
        wait_done(d0);
        check_int("bp_blk_count", blk_q.size(), 3);
        check_int("bp_ct_count", ct_q.size(), 3);
        if (ct_q.size() == 3) begin
            check_vec("bp_ct0_data", ct_q[0].data, {16{8'h4B}});
            check_int("bp_ct0_last", int'(ct_q[0].last), 0);
            check_vec("bp_ct1_data", ct_q[1].data, {16{8'h78}});
            check_vec("bp_ct2_data", ct_q[2].data, 128'h6969);
            check_int("bp_ct2_bytes_last", int'({ct_q[2].bytes, ct_q[2].last}), 5);
        end

        // Reset while in MSG: immediate return to idle, no core_start, then a clean run.
        pulse_start(1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!s_msg_ready_o && n < 50) begin @(negedge clk); n++; end
            check_int("rst_reached_msg", int'(s_msg_ready_o), 1);
        end
        cs0 = cs_cnt;
        rst = 1'b1;
        #1;
        check_idle("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_int("midrst_no_core_start", cs_cnt - cs0, 0);
        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
